// File: rtl/approx_adder_pkg.sv
// -----------------------------------------------------------------------------
// approx_adder_pkg
//   Shared types for the approximate ripple-carry pipeline adder.
//   - cell_kind_e : which full-adder equation a bit position uses.
//   - stage_t     : payload carried between pipeline stages. Fields are sized
//                   for the largest supported operand width; each instance only
//                   uses the low WIDTH / WIDTH+1 bits and the rest stay zero.
//   - cfg_ok()    : elaboration-time parameter legality check.
// -----------------------------------------------------------------------------
package approx_adder_pkg;

  // Largest operand width the payload struct can carry.
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic {
    CELL_EXACT  = 1'b0,
    CELL_APPROX = 1'b1
  } cell_kind_e;

  // One pipeline slot. 'sum' fills in slice by slice as the carry chain is
  // resolved; 'carry' is the approximate chain's carry into the next slice.
  // 'exact_sum' holds the shadow result: resolved slices plus, at the first
  // unresolved bit position, the shadow carry into the next slice.
  typedef struct packed {
    logic                 valid;
    logic                 approx;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic [MAX_WIDTH:0]   sum;
    logic                 carry;
    logic [MAX_WIDTH:0]   exact_sum;
  } stage_t;

  // Legal configurations: the carry chain splits evenly across the stages,
  // the approximate region fits inside the operand, and the accumulator can
  // hold at least one full-scale error value.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned approx_bits,
                                input int unsigned stages,
                                input int unsigned acc_w);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (stages >= 1) && ((width % stages) == 0) &&
           (approx_bits <= width) && (acc_w >= width + 1);
  endfunction

endpackage

// File: rtl/approx_rc_pipe_adder_cell.sv
// -----------------------------------------------------------------------------
// approx_fa_cell
//   One full-adder bit with a runtime choice between the exact and the
//   approximate equations.
//   Ports:
//     x, y        operand bits
//     z           carry in
//     sel_approx  1 = approximate cell, 0 = exact cell
//     s           sum bit
//     cout        carry out
//   Approximate cell: s = (x ^ y) & ~z, cout = y | z.
//   Exact cell:       s = x ^ y ^ z,    cout = majority(x, y, z).
// -----------------------------------------------------------------------------
module approx_fa_cell
  import approx_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic sel_approx,
  output logic s,
  output logic cout
);

  cell_kind_e kind;

  // NOTE: every output of a combinational block gets a value on every path
  // (here via defaults first), otherwise synthesis infers a latch.
  always_comb begin
    kind = sel_approx ? CELL_APPROX : CELL_EXACT;
    s    = x ^ y ^ z;
    cout = (x & y) | (x & z) | (y & z);
    case (kind)
      CELL_APPROX: begin
        s    = (x ^ y) & ~z;
        cout = y | z;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/approx_rc_pipe_adder.sv
// -----------------------------------------------------------------------------
// approx_rc_pipe_adder
//   Pipelined ripple-carry adder whose low APPROX_BITS positions may use an
//   approximate full-adder cell, selected per beat. A shadow exact sum travels
//   alongside each beat so the error of every result is known, and running
//   error statistics are kept over retired beats.
//
//   Parameters:
//     WIDTH        operand width; results are WIDTH+1 bits
//     APPROX_BITS  LSB positions that use the approximate cell in approx mode
//     STAGES       pipeline depth; each stage resolves WIDTH/STAGES chain bits
//     ACC_W        width of the error accumulator and the beat counter
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid/in_ready     operand stream handshake
//     in_a, in_b, in_approx operands and per-beat mode (1 = approximate)
//     out_valid/out_ready   result stream handshake
//     out_sum               result under the captured mode
//     out_err               |out_sum - exact sum| for the presented beat
//     stat_clr              synchronous clear of the statistics
//     stat_acc              saturating sum of out_err over retired beats
//     stat_max              largest out_err over retired beats
//     stat_cnt              saturating count of retired beats
//
//   The whole pipeline moves together: it advances whenever the output slot
//   is empty or being drained, so a stall freezes every stage in place.
// -----------------------------------------------------------------------------
module approx_rc_pipe_adder
  import approx_adder_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 2,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned ACC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  input  logic             stat_clr,
  output logic [ACC_W-1:0] stat_acc,
  output logic [WIDTH:0]   stat_max,
  output logic [ACC_W-1:0] stat_cnt
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam logic [ACC_W-1:0] CNT_ONE = ACC_W'(1);

  if (!cfg_ok(WIDTH, APPROX_BITS, STAGES, ACC_W)) begin : g_cfg_err
    $error("approx_rc_pipe_adder: illegal WIDTH/APPROX_BITS/STAGES/ACC_W combination");
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage payloads
  // ---------------------------------------------------------------------------
  stage_t head;
  stage_t stage_nxt [STAGES];
  stage_t stage_q   [STAGES];
  stage_t tail;

  // Incoming beat: nothing resolved yet, both carry chains start at 0.
  always_comb begin
    head                 = '0;
    head.valid           = in_valid;
    head.approx          = in_approx;
    head.a[WIDTH-1:0]    = in_a;
    head.b[WIDTH-1:0]    = in_b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        up;
    stage_t        nxt;
    logic [SW-1:0] s;
    logic [SW:0]   c;
    logic [SW:0]   ex;

    if (k == 0) begin : g_first
      assign up = head;
    end else begin : g_link
      assign up = stage_q[k-1];
    end

    // Approximate/exact carry chain for this stage's slice.
    assign c[0] = up.carry;

    for (genvar j = 0; j < SW; j++) begin : g_bit
      localparam int unsigned POS    = k * SW + j;
      localparam bit          IN_APX = (POS < APPROX_BITS);

      approx_fa_cell u_cell (
        .x          (up.a[POS]),
        .y          (up.b[POS]),
        .z          (c[j]),
        .sel_approx (up.approx & IN_APX),
        .s          (s[j]),
        .cout       (c[j+1])
      );
    end

    // Shadow exact slice: the carry-in sits at the slice's LSB position and is
    // overwritten by the slice result, whose top bit becomes the next carry.
    assign ex = {1'b0, up.a[k*SW +: SW]}
              + {1'b0, up.b[k*SW +: SW]}
              + {{SW{1'b0}}, up.exact_sum[k*SW]};

    always_comb begin
      nxt                         = up;
      nxt.sum[k*SW +: SW]         = s;
      nxt.carry                   = c[SW];
      nxt.exact_sum[k*SW +: SW+1] = ex;
      if (k == STAGES - 1) begin
        nxt.sum[WIDTH] = c[SW];
      end
    end

    assign stage_nxt[k] = nxt;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its upstream value from before this edge.
  // NOTE: payload registers are reset along with the valid bits because the
  // output fields are visible directly and must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_nxt[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output and per-beat error
  // ---------------------------------------------------------------------------
  logic [WIDTH+1:0] diff;
  logic [WIDTH+1:0] mag;

  assign tail      = stage_q[STAGES-1];
  assign out_valid = tail.valid;
  assign out_sum   = tail.sum[WIDTH:0];

  // Two extra bits keep the signed difference of two WIDTH+1-bit values from
  // wrapping; the magnitude always fits back into WIDTH+1 bits.
  assign diff    = {1'b0, tail.sum[WIDTH:0]} - {1'b0, tail.exact_sum[WIDTH:0]};
  assign mag     = diff[WIDTH+1] ? -diff : diff;
  assign out_err = mag[WIDTH:0];

  // The final stage's operands, chain carry and padding bits have no reader.
  logic unused_tail;
  assign unused_tail = ^{mag[WIDTH+1], tail};

  // ---------------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------------
  logic             retire;
  logic [ACC_W-1:0] err_ext;
  logic [ACC_W:0]   acc_sum;

  assign retire = out_valid & out_ready;

  always_comb begin
    err_ext          = '0;
    err_ext[WIDTH:0] = out_err;
  end

  assign acc_sum = {1'b0, stat_acc} + {1'b0, err_ext};

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_acc <= '0;
      stat_cnt <= '0;
      stat_max <= '0;
    end else if (stat_clr) begin
      // A clear that coincides with a retire restarts the statistics from
      // that beat instead of dropping it.
      if (retire) begin
        stat_acc <= err_ext;
        stat_cnt <= CNT_ONE;
        stat_max <= out_err;
      end else begin
        stat_acc <= '0;
        stat_cnt <= '0;
        stat_max <= '0;
      end
    end else if (retire) begin
      stat_acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      if (~&stat_cnt) begin
        stat_cnt <= stat_cnt + CNT_ONE;
      end
      if (out_err > stat_max) begin
        stat_max <= out_err;
      end
    end
  end

endmodule

// File: tb/tb_approx_rc_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_approx_rc_pipe_adder
//   Self-checking bench for approx_rc_pipe_adder (WIDTH=8, APPROX_BITS=2,
//   STAGES=2). Expected results come from a bit-serial model of the cell
//   equations and plain integer arithmetic for the exact sum and the error.
//   Inputs change 1 time unit after the rising edge; outputs are read 1-2
//   time units after it.
// -----------------------------------------------------------------------------
module tb_approx_rc_pipe_adder;

  localparam int WIDTH       = 8;
  localparam int APPROX_BITS = 2;
  localparam int STAGES      = 2;
  localparam int ACC_W       = 32;
  localparam int N_RANDOM    = 10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;
  logic             stat_clr;
  logic [ACC_W-1:0] stat_acc;
  logic [WIDTH:0]   stat_max;
  logic [ACC_W-1:0] stat_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  approx_rc_pipe_adder #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS),
    .STAGES      (STAGES),
    .ACC_W       (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_approx (in_approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .stat_clr  (stat_clr),
    .stat_acc  (stat_acc),
    .stat_max  (stat_max),
    .stat_cnt  (stat_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input bit apx);
    logic [WIDTH:0] r;
    logic c, x, y;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x = a[i];
      y = b[i];
      if (apx && i < APPROX_BITS) begin
        r[i] = (x ^ y) & ~c;
        c    = y | c;
      end else begin
        r[i] = x ^ y ^ c;
        c    = (x & y) | (c & (x ^ y));
      end
    end
    r[WIDTH] = c;
    return r;
  endfunction

  function automatic logic [WIDTH:0] model_err(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input bit apx);
    int d;
    d = int'(model_sum(a, b, apx)) - (int'(a) + int'(b));
    if (d < 0) d = -d;
    return d[WIDTH:0];
  endfunction

  // Drives one beat with out_ready=1 and returns the result together with the
  // number of rising edges from acceptance (inclusive) to out_valid.
  task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit apx, output logic [WIDTH:0] sum,
                          output logic [WIDTH:0] err, output int lat);
    int guard;
    guard     = 0;
    in_a      = a;
    in_b      = b;
    in_approx = apx;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    sum = out_sum;
    err = out_err;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_approx = 1'b0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_sum !== '0) $display("FAIL reset_out_sum: got %h want 000", out_sum); else n_pass++;
    n_checks++; if (out_err !== '0) $display("FAIL reset_out_err: got %h want 000", out_err); else n_pass++;
    n_checks++; if (stat_cnt !== '0 || stat_acc !== '0 || stat_max !== '0)
      $display("FAIL reset_stats: got cnt=%0d acc=%0d max=%0d want 0/0/0", stat_cnt, stat_acc, stat_max);
    else n_pass++;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic [WIDTH:0] s, e;
    int lat;
    send_one(8'h00, 8'h01, 1'b1, s, e, lat);
    n_checks++; if (s !== 9'h005) $display("FAIL basic_apx_sum: got %h want 005", s); else n_pass++;
    n_checks++; if (e !== 9'd4) $display("FAIL basic_apx_err: got %0d want 4", e); else n_pass++;
    n_checks++; if (lat !== STAGES) $display("FAIL basic_latency: got %0d want %0d", lat, STAGES); else n_pass++;
    send_one(8'h00, 8'h01, 1'b0, s, e, lat);
    n_checks++; if (s !== 9'h001) $display("FAIL basic_exact_sum: got %h want 001", s); else n_pass++;
    n_checks++; if (e !== 9'd0) $display("FAIL basic_exact_err: got %0d want 0", e); else n_pass++;
  endtask

  task automatic test_corners();
    logic [WIDTH:0] s, e;
    int lat;
    send_one(8'hFF, 8'hFF, 1'b1, s, e, lat);
    n_checks++; if (s !== 9'h1FC) $display("FAIL ff_ff_sum: got %h want 1fc", s); else n_pass++;
    n_checks++; if (e !== 9'd2) $display("FAIL ff_ff_err: got %0d want 2", e); else n_pass++;
    send_one(8'h03, 8'h01, 1'b1, s, e, lat);
    n_checks++; if (s !== 9'h004) $display("FAIL 03_01_sum: got %h want 004", s); else n_pass++;
    n_checks++; if (e !== 9'd0) $display("FAIL 03_01_err: got %0d want 0", e); else n_pass++;
  endtask

  task automatic test_stats();
    logic [WIDTH:0] s, e;
    int lat;
    @(posedge clk); #1;
    n_checks++; if (stat_cnt !== 32'd4) $display("FAIL stats_cnt: got %0d want 4", stat_cnt); else n_pass++;
    n_checks++; if (stat_acc !== 32'd6) $display("FAIL stats_acc: got %0d want 6", stat_acc); else n_pass++;
    n_checks++; if (stat_max !== 9'd4) $display("FAIL stats_max: got %0d want 4", stat_max); else n_pass++;
    // Clear on the very cycle the err=2 beat retires.
    send_one(8'hFF, 8'hFF, 1'b1, s, e, lat);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    n_checks++; if (stat_cnt !== 32'd1 || stat_acc !== 32'd2 || stat_max !== 9'd2)
      $display("FAIL stats_clr_retire: got cnt=%0d acc=%0d max=%0d want 1/2/2", stat_cnt, stat_acc, stat_max);
    else n_pass++;
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    n_checks++; if (stat_cnt !== '0 || stat_acc !== '0 || stat_max !== '0)
      $display("FAIL stats_clr_idle: got cnt=%0d acc=%0d max=%0d want 0/0/0", stat_cnt, stat_acc, stat_max);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] va [4];
    logic [WIDTH-1:0] vb [4];
    bit               vp [4];
    logic [WIDTH:0]   q_sum [$];
    logic [WIDTH:0]   q_err [$];
    logic [WIDTH:0]   held_sum, held_err;
    bit               was_stalled;
    int               sent, got, t;
    va = '{8'h12, 8'hFF, 8'h80, 8'h0F};
    vb = '{8'h34, 8'h01, 8'h80, 8'h0F};
    vp = '{1'b1, 1'b1, 1'b0, 1'b1};
    sent = 0; got = 0; t = 0; was_stalled = 1'b0;
    held_sum = '0; held_err = '0;
    while ((sent < 4 || q_sum.size() > 0) && t < 100) begin
      out_ready = !(t >= 3 && t <= 5);
      if (sent < 4) begin
        in_valid  = 1'b1;
        in_a      = va[sent];
        in_b      = vb[sent];
        in_approx = vp[sent];
      end else begin
        in_valid  = 1'b0;
      end
      #1;
      if (was_stalled) begin
        n_checks++; if (out_sum !== held_sum || out_err !== held_err)
          $display("FAIL b2b_hold_stable t=%0d: got %h/%0d want %h/%0d", t, out_sum, out_err, held_sum, held_err);
        else n_pass++;
      end
      if (out_valid && !out_ready) begin
        n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready_stall t=%0d: got %b want 0", t, in_ready); else n_pass++;
        held_sum    = out_sum;
        held_err    = out_err;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q_sum.size() == 0) begin
          $display("FAIL b2b_extra_beat t=%0d: got %h want no beat", t, out_sum);
        end else if (out_sum !== q_sum[0] || out_err !== q_err[0]) begin
          $display("FAIL b2b_beat%0d: got %h/%0d want %h/%0d", got, out_sum, out_err, q_sum[0], q_err[0]);
        end else begin
          n_pass++;
        end
        if (q_sum.size() > 0) begin
          void'(q_sum.pop_front());
          void'(q_err.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(model_sum(in_a, in_b, in_approx));
        q_err.push_back(model_err(in_a, in_b, in_approx));
        sent++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (got !== 4 || t >= 100) $display("FAIL b2b_beat_count: got %0d beats in %0d cycles want 4", got, t); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit seen;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h11;
    in_b      = 8'h22;
    in_approx = 1'b1;
    @(posedge clk); #1;
    in_a      = 8'h33;
    in_b      = 8'h44;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_inflight: got out_valid=%b want 1", out_valid); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midrst_no_output: got out_valid=1 want 0"); else n_pass++;
    n_checks++; if (stat_cnt !== '0 || stat_acc !== '0 || stat_max !== '0)
      $display("FAIL midrst_stats: got cnt=%0d acc=%0d max=%0d want 0/0/0", stat_cnt, stat_acc, stat_max);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [WIDTH:0] q_sum [$];
    logic [WIDTH:0] q_err [$];
    int unsigned    m_cnt, m_acc, m_max;
    int             sent, t, prints;
    m_cnt = 0; m_acc = 0; m_max = 0;
    sent = 0; t = 0; prints = 0;
    while ((sent < N_RANDOM || q_sum.size() > 0) && t < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < N_RANDOM && $urandom_range(0, 3) != 0) begin
        in_valid  = 1'b1;
        in_a      = WIDTH'($urandom);
        in_b      = WIDTH'($urandom);
        in_approx = $urandom_range(0, 1) != 0;
      end else begin
        in_valid  = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q_sum.size() == 0 || out_sum !== q_sum[0] || out_err !== q_err[0]) begin
          if (prints < 10) begin
            if (q_sum.size() == 0) $display("FAIL rand_extra_beat t=%0d: got %h want no beat", t, out_sum);
            else $display("FAIL rand_beat t=%0d: got %h/%0d want %h/%0d", t, out_sum, out_err, q_sum[0], q_err[0]);
          end
          prints++;
        end else begin
          n_pass++;
        end
        if (q_sum.size() > 0) begin
          m_cnt++;
          m_acc += q_err[0];
          if (q_err[0] > m_max) m_max = q_err[0];
          void'(q_sum.pop_front());
          void'(q_err.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(model_sum(in_a, in_b, in_approx));
        q_err.push_back(model_err(in_a, in_b, in_approx));
        sent++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (sent != N_RANDOM || t >= 60000) $display("FAIL rand_timeout: got %0d beats sent want %0d", sent, N_RANDOM); else n_pass++;
    n_checks++; if (stat_cnt !== m_cnt) $display("FAIL rand_stat_cnt: got %0d want %0d", stat_cnt, m_cnt); else n_pass++;
    n_checks++; if (stat_acc !== m_acc) $display("FAIL rand_stat_acc: got %0d want %0d", stat_acc, m_acc); else n_pass++;
    n_checks++; if (stat_max !== m_max[WIDTH:0]) $display("FAIL rand_stat_max: got %0d want %0d", stat_max, m_max); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stats();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
